memory_game_ctrl: RTL and testbench
===================================

MEMORY_GAME_CTRL -- requirements
Module: memory_game_ctrl

Interface
REQ-001 Parameter: SHOW_ON_CYC, 4, cycles each pattern symbol is lit.
REQ-002 Parameter: SHOW_OFF_CYC, 2, dark cycles after each lit symbol.
REQ-003 Parameter: TIMEOUT_CYC, 64, max cycles allowed between player presses.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  level; sampled only in IDLE, WIN and LOSE.
REQ-007 Port: button  input  4  player keys; one-hot when valid.
REQ-008 Port: pat_data  input  2  pattern symbol at address {stage, step}, supplied combinationally by pattern storage.
REQ-009 Port: stage  output  2  current stage 0..2; registered.
REQ-010 Port: step  output  2  current step index; registered; pattern-storage address.
REQ-011 Port: led  output  4  one-hot of pat_data in SHOW_ON, else 0.
REQ-012 Port: busy  output  1  high in every state except IDLE, WIN and LOSE.
REQ-013 Port: win / lose  output  1 each  registered, mutually exclusive, held until start or rst.

Function
REQ-014 States: IDLE, SHOW_ON, SHOW_OFF, WAIT_IN, WAIT_REL, WIN, LOSE.
REQ-015 Stage s (0..2) has s+2 steps; last step index = s+1.
REQ-016 IDLE/WIN/LOSE with start=1: next cycle SHOW_ON, stage=0, step=0, win=0, lose=0, cycle counter cleared.
REQ-017 SHOW_ON lasts exactly SHOW_ON_CYC cycles, then SHOW_OFF.
REQ-018 SHOW_OFF lasts exactly SHOW_OFF_CYC cycles.
REQ-019 At the end of SHOW_OFF: if step < last, step+1 and go to SHOW_ON; otherwise step=0 and go to WAIT_IN.
REQ-020 Press event: button != 0 this cycle and button == 0 in the previous cycle. The previous-cycle register is cleared on rst and on entry to WAIT_IN.
REQ-021 In WAIT_IN, a press event is correct only if button is one-hot and its encoded index (bit0->0 ... bit3->3) equals pat_data.
REQ-022 Correct press: go to WAIT_REL; step is held.
REQ-023 Incorrect press (wrong key or more than one bit set): go to LOSE next cycle, lose=1.
REQ-024 WAIT_IN with no press for TIMEOUT_CYC consecutive cycles: go to LOSE, lose=1. The counter restarts on entry to WAIT_IN.
REQ-025 In WAIT_REL, when button == 0:
  - if step < last: step+1, return to WAIT_IN.
  - if step == last and stage < 2: stage+1, step=0, go to SHOW_ON.
  - if step == last and stage == 2: go to WIN, win=1.
REQ-026 Buttons are ignored in SHOW_ON, SHOW_OFF and WAIT_REL; releases and new presses there have no effect.
REQ-027 stage and step never exceed 2 and last respectively. There is no wrap-around; the next start reinitialises both.
REQ-028 WIN/LOSE hold stage and step at their final values.
REQ-029 Press event and timeout expiry in the same cycle: the press takes priority.
REQ-030 Counters are wide enough for max(SHOW_ON_CYC, SHOW_OFF_CYC, TIMEOUT_CYC) with no overflow.

Reset
REQ-031 rst=1 at a clock edge forces, regardless of state (including mid-show or mid-input), on the next cycle: state=IDLE, stage=0, step=0, led=0, busy=0, win=0, lose=0, all counters 0.
REQ-032 rst takes priority over start and button in the same cycle.
REQ-033 No output may take an X or undefined value after the first reset edge.

Verification
REQ-034 Show timing. Stimulus: rst, then start pulse, pat_data={stage0: 2,1}. Required: led=0100 for 4 cycles, 0 for 2, 0010 for 4, 0 for 2; then WAIT_IN with busy=1.
REQ-035 Full win. Stimulus: correct single-key presses with releases for all 2+3+4 steps. Required: stage steps 0->1->2; win=1 and busy=0 one cycle after the final release.
REQ-036 Wrong key. Stimulus: stage 0, step 0, pat_data=3, press button=0001. Required: lose=1 next cycle; stage=0, step=0 held.
REQ-037 Multi-key and timeout. Stimulus: button=1001 when 3 is expected -> lose. Separately, no input for 64 cycles in WAIT_IN -> lose=1 exactly at cycle 64.
REQ-038 Held key. Stimulus: correct key held across 20 cycles. Required: counts as one press; step advances only after release.
REQ-039 Reset mid-game. Stimulus: rst asserted in SHOW_ON of stage 1. Required: next cycle IDLE with all outputs 0. A start asserted alongside rst is ignored.

Source files
------------

// File: rtl/memory_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : memory_game_ctrl
// Description : Simon-style memory game sequencer: shows a growing pattern on
//               the LEDs, then checks the player's key presses against it.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_game_ctrl #(
    parameter int SHOW_ON_CYC  = 4,
    parameter int SHOW_OFF_CYC = 2,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] button,
    input  logic [1:0] pat_data,
    output logic [1:0] stage,
    output logic [1:0] step,
    output logic [3:0] led,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    localparam int c_max_ab  = (SHOW_ON_CYC > SHOW_OFF_CYC) ? SHOW_ON_CYC : SHOW_OFF_CYC;
    localparam int c_max_cyc = (c_max_ab > TIMEOUT_CYC) ? c_max_ab : TIMEOUT_CYC;
    localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

    localparam logic [c_cnt_w-1:0] c_on_last   = c_cnt_w'(SHOW_ON_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_off_last  = c_cnt_w'(SHOW_OFF_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_tout_last = c_cnt_w'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHOW_ON  = 3'd1,
        S_SHOW_OFF = 3'd2,
        S_WAIT_IN  = 3'd3,
        S_WAIT_REL = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_stage, w_stage_nxt;
    logic [1:0]           r_step, w_step_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic                 r_win, w_win_nxt;
    logic                 r_lose, w_lose_nxt;
    logic [3:0]           r_btn_prev, w_btn_prev_nxt;

    logic [1:0]           w_last;
    logic                 w_press;
    logic                 w_onehot;
    logic [1:0]           w_key_idx;
    logic                 w_key_ok;

    assign w_last   = r_stage + 2'd1;
    assign w_press  = (button != 4'd0) && (r_btn_prev == 4'd0);
    assign w_key_ok = w_onehot && (w_key_idx == pat_data);

    // Any pattern other than exactly one bit set is an invalid key
    always_comb begin
        w_onehot  = 1'b1;
        w_key_idx = 2'd0;
        case (button)
            4'b0001: w_key_idx = 2'd0;
            4'b0010: w_key_idx = 2'd1;
            4'b0100: w_key_idx = 2'd2;
            4'b1000: w_key_idx = 2'd3;
            default: w_onehot  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_stage    <= 2'd0;
            r_step     <= 2'd0;
            r_cnt      <= '0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
            r_btn_prev <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_stage    <= w_stage_nxt;
            r_step     <= w_step_nxt;
            r_cnt      <= w_cnt_nxt;
            r_win      <= w_win_nxt;
            r_lose     <= w_lose_nxt;
            r_btn_prev <= w_btn_prev_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_stage_nxt    = r_stage;
        w_step_nxt     = r_step;
        w_cnt_nxt      = r_cnt;
        w_win_nxt      = r_win;
        w_lose_nxt     = r_lose;
        w_btn_prev_nxt = button;

        case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    w_state_nxt = S_SHOW_ON;
                    w_stage_nxt = 2'd0;
                    w_step_nxt  = 2'd0;
                    w_cnt_nxt   = '0;
                    w_win_nxt   = 1'b0;
                    w_lose_nxt  = 1'b0;
                end
            end
            S_SHOW_ON: begin
                if (r_cnt == c_on_last) begin
                    w_state_nxt = S_SHOW_OFF;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_SHOW_OFF: begin
                if (r_cnt == c_off_last) begin
                    w_cnt_nxt = '0;
                    if (r_step < w_last) begin
                        w_step_nxt  = r_step + 2'd1;
                        w_state_nxt = S_SHOW_ON;
                    end else begin
                        w_step_nxt     = 2'd0;
                        w_state_nxt    = S_WAIT_IN;
                        w_btn_prev_nxt = 4'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_IN: begin
                // A press in the expiry cycle still wins over the timeout
                if (w_press) begin
                    w_cnt_nxt = '0;
                    if (w_key_ok) begin
                        w_state_nxt = S_WAIT_REL;
                    end else begin
                        w_state_nxt = S_LOSE;
                        w_lose_nxt  = 1'b1;
                    end
                end else if (r_cnt == c_tout_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_LOSE;
                    w_lose_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_REL: begin
                if (button == 4'd0) begin
                    w_cnt_nxt = '0;
                    if (r_step < w_last) begin
                        w_step_nxt     = r_step + 2'd1;
                        w_state_nxt    = S_WAIT_IN;
                        w_btn_prev_nxt = 4'd0;
                    end else if (r_stage < 2'd2) begin
                        w_stage_nxt = r_stage + 2'd1;
                        w_step_nxt  = 2'd0;
                        w_state_nxt = S_SHOW_ON;
                    end else begin
                        w_state_nxt = S_WIN;
                        w_win_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        led = 4'd0;
        if (r_state == S_SHOW_ON) begin
            led = 4'b0001 << pat_data;
        end
    end

    assign busy  = (r_state != S_IDLE) && (r_state != S_WIN) && (r_state != S_LOSE);
    assign stage = r_stage;
    assign step  = r_step;
    assign win   = r_win;
    assign lose  = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_memory_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_game_ctrl
// Description : Directed self-checking bench for memory_game_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] button = 4'd0;
    logic [1:0] pat_data;
    logic [1:0] stage;
    logic [1:0] step;
    logic [3:0] led;
    logic       busy;
    logic       win;
    logic       lose;

    logic [1:0] pat [0:3][0:3];
    int         n_pass  = 0;
    int         n_total = 0;

    // Pattern storage: combinational read at address {stage, step}
    assign pat_data = pat[stage][step];

    memory_game_ctrl #(
        .SHOW_ON_CYC (4),
        .SHOW_OFF_CYC(2),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .button  (button),
        .pat_data(pat_data),
        .stage   (stage),
        .step    (step),
        .led     (led),
        .busy    (busy),
        .win     (win),
        .lose    (lose)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Entered in the first SHOW_ON cycle; returns in the first WAIT_IN cycle
    task automatic show_seq(input int s);
        logic [3:0] exp_led;
        for (int k = 0; k <= s + 1; k++) begin
            exp_led = 4'b0001 << pat[s][k];
            chk("show_stage", 32'(stage), 32'(s));
            chk("show_step", 32'(step), 32'(k));
            for (int i = 0; i < 4; i++) begin
                chk("show_on_led", 32'(led), 32'(exp_led));
                tick();
            end
            for (int i = 0; i < 2; i++) begin
                chk("show_off_led", 32'(led), 32'(0));
                chk("show_off_busy", 32'(busy), 32'(1));
                tick();
            end
        end
        chk("wait_in_busy", 32'(busy), 32'(1));
        chk("wait_in_step", 32'(step), 32'(0));
        chk("wait_in_led", 32'(led), 32'(0));
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_win", 32'(win), 32'(0));
        chk("start_lose", 32'(lose), 32'(0));
        chk("start_stage", 32'(stage), 32'(0));
    endtask

    initial begin
        logic [3:0] key;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                pat[a][b] = 2'd0;
        pat[0][0] = 2'd2; pat[0][1] = 2'd1;
        pat[1][0] = 2'd0; pat[1][1] = 2'd3; pat[1][2] = 2'd2;
        pat[2][0] = 2'd1; pat[2][1] = 2'd2; pat[2][2] = 2'd0; pat[2][3] = 2'd3;

        // Reset state
        tick();
        tick();
        chk("rst_stage", 32'(stage), 32'(0));
        chk("rst_step", 32'(step), 32'(0));
        chk("rst_led", 32'(led), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_win", 32'(win), 32'(0));
        chk("rst_lose", 32'(lose), 32'(0));
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'(0));

        // Full game to a win; stage 1 step 0 key is held for 20 cycles
        start_game();
        for (int s = 0; s < 3; s++) begin
            show_seq(s);
            for (int k = 0; k <= s + 1; k++) begin
                chk("in_stage", 32'(stage), 32'(s));
                chk("in_step", 32'(step), 32'(k));
                key = 4'b0001 << pat[s][k];
                button = key;
                tick();
                chk("rel_step_held", 32'(step), 32'(k));
                chk("rel_lose", 32'(lose), 32'(0));
                if (s == 1 && k == 0) begin
                    repeat (19) tick();
                    chk("held_step", 32'(step), 32'(0));
                    chk("held_busy", 32'(busy), 32'(1));
                    chk("held_lose", 32'(lose), 32'(0));
                end
                button = 4'd0;
                tick();
                if (k < s + 1) begin
                    chk("adv_step", 32'(step), 32'(k + 1));
                    chk("adv_led", 32'(led), 32'(0));
                end else if (s < 2) begin
                    chk("adv_stage", 32'(stage), 32'(s + 1));
                    chk("adv_stage_step", 32'(step), 32'(0));
                end
            end
        end
        chk("win_win", 32'(win), 32'(1));
        chk("win_lose", 32'(lose), 32'(0));
        chk("win_busy", 32'(busy), 32'(0));
        chk("win_stage", 32'(stage), 32'(2));
        chk("win_step", 32'(step), 32'(3));
        tick();
        chk("win_hold", 32'(win), 32'(1));

        // Wrong key: expected 3, pressed key 0
        pat[0][0] = 2'd3;
        start_game();
        show_seq(0);
        button = 4'b0001;
        tick();
        chk("wrong_lose", 32'(lose), 32'(1));
        chk("wrong_win", 32'(win), 32'(0));
        chk("wrong_busy", 32'(busy), 32'(0));
        chk("wrong_stage", 32'(stage), 32'(0));
        chk("wrong_step", 32'(step), 32'(0));
        button = 4'd0;
        tick();
        chk("lose_hold", 32'(lose), 32'(1));

        // Multi-key press with the correct bit included
        start_game();
        show_seq(0);
        button = 4'b1001;
        tick();
        chk("multi_lose", 32'(lose), 32'(1));
        chk("multi_busy", 32'(busy), 32'(0));
        button = 4'd0;

        // Timeout: 64 idle cycles in WAIT_IN
        start_game();
        show_seq(0);
        repeat (63) tick();
        chk("tout_63_lose", 32'(lose), 32'(0));
        chk("tout_63_busy", 32'(busy), 32'(1));
        tick();
        chk("tout_64_lose", 32'(lose), 32'(1));
        chk("tout_64_busy", 32'(busy), 32'(0));

        // Correct press on the expiry cycle beats the timeout
        start_game();
        show_seq(0);
        repeat (63) tick();
        button = 4'b1000;
        tick();
        chk("prio_lose", 32'(lose), 32'(0));
        chk("prio_busy", 32'(busy), 32'(1));
        button = 4'd0;
        tick();
        chk("prio_step", 32'(step), 32'(1));
        button = 4'b0010;
        tick();
        button = 4'd0;
        tick();
        chk("mid_stage", 32'(stage), 32'(1));
        chk("mid_led", 32'(led), 32'(4'b0001));

        // Reset in stage 1 SHOW_ON with start asserted alongside
        tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        chk("mrst_stage", 32'(stage), 32'(0));
        chk("mrst_step", 32'(step), 32'(0));
        chk("mrst_led", 32'(led), 32'(0));
        chk("mrst_busy", 32'(busy), 32'(0));
        chk("mrst_win", 32'(win), 32'(0));
        chk("mrst_lose", 32'(lose), 32'(0));
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("mrst_idle_busy", 32'(busy), 32'(0));
        chk("mrst_idle_led", 32'(led), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
